// File: rtl/cmp_qualified_pkg.sv
// Shared definitions for the qualified comparator: compare-mode encodings,
// FSM state type and a helper for the run-counter width.
package cmp_qualified_pkg;

    localparam logic [2:0] CMP_LE = 3'd0;
    localparam logic [2:0] CMP_LT = 3'd1;
    localparam logic [2:0] CMP_EQ = 3'd2;
    localparam logic [2:0] CMP_NE = 3'd3;
    localparam logic [2:0] CMP_GE = 3'd4;
    localparam logic [2:0] CMP_GT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    // Bits needed to count 0..hold inclusive.
    function automatic int unsigned run_width(int unsigned hold);
        return (hold < 1) ? 1 : $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/cmp_qualified_core.sv
// Combinational magnitude compare of a against b under one of six modes.
// Reserved modes (6/7) always report false.
module cmp_qualified_core
    import cmp_qualified_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             res
);

    logic lt;
    logic eq;

    // Derive less-than / equal once, then select the requested relation.
    always_comb begin
        if (SIGNED != 0) begin
            lt = $signed(a) < $signed(b);
        end else begin
            lt = a < b;
        end
        eq = (a == b);
        case (mode)
            CMP_LE:  res = lt | eq;
            CMP_LT:  res = lt;
            CMP_EQ:  res = eq;
            CMP_NE:  res = ~eq;
            CMP_GE:  res = ~lt;
            CMP_GT:  res = ~(lt | eq);
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_qualified.sv
// Registered, debounced magnitude comparator. A compare is qualified once it
// has been true for HOLD consecutive valid samples under an unchanged mode.
module cmp_qualified
    import cmp_qualified_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned HOLD   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             o_valid,
    output logic             o,
    output logic             o_hold,
    output logic             o_rise,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      RUN_W  = run_width(HOLD);
    localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);

    logic             res;
    logic             mode_chg;
    logic [2:0]       mode_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    state_e           state_q;
    state_e           state_d;

    cmp_qualified_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a    (a),
        .b    (b),
        .mode (mode),
        .res  (res)
    );

    // Next run length and FSM state for the current sample (used only when valid).
    always_comb begin
        mode_chg = (mode != mode_q);

        if (!res) begin
            run_d = '0;
        end else if (mode_chg) begin
            run_d = RUN_W'(1);
        end else if (run_q >= HOLD_R) begin
            run_d = HOLD_R;
        end else begin
            run_d = run_q + RUN_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (res) state_d = (HOLD == 1) ? ST_HELD : ST_ARM;
            end
            ST_ARM: begin
                if (!res) state_d = ST_IDLE;
                else if (run_d == HOLD_R) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!res) state_d = ST_IDLE;
                // A new mode must re-earn qualification unless one sample suffices.
                else if (mode_chg && (HOLD > 1)) state_d = ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample registers, run counter, FSM and saturating match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o         <= 1'b0;
            o_hold    <= 1'b0;
            o_rise    <= 1'b0;
            match_cnt <= '0;
            mode_q    <= '0;
            run_q     <= '0;
            state_q   <= ST_IDLE;
        end else begin
            o_valid <= in_valid;
            o_rise  <= 1'b0;
            if (in_valid) begin
                o       <= res;
                mode_q  <= mode;
                run_q   <= run_d;
                state_q <= state_d;
                o_hold  <= (state_d == ST_HELD);
                o_rise  <= (state_d == ST_HELD) && (state_q != ST_HELD);
                if (res && (match_cnt != '1)) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cmp_qualified.sv
// Bench for cmp_qualified: two instances share stimulus.
//   index 0: unsigned, HOLD=4, CNT_W=16
//   index 1: signed,   HOLD=1, CNT_W=4
module tb_cmp_qualified;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] mode;

    logic        ov_u, o_u, h_u, r_u;
    logic [15:0] cnt_u;
    logic        ov_s, o_s, h_s, r_s;
    logic [3:0]  cnt_s;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, one slot per instance.
    int       m_run  [2];
    bit       m_hold [2];
    bit       m_rise [2];
    bit       m_o    [2];
    bit       m_valid[2];
    int       m_cnt  [2];
    bit [2:0] m_mq   [2];
    int       hold_of[2] = '{4, 1};
    int       cmax   [2] = '{65535, 15};
    bit       sgn    [2] = '{1'b0, 1'b1};

    cmp_qualified #(
        .WIDTH  (8),
        .SIGNED (0),
        .HOLD   (4),
        .CNT_W  (16)
    ) dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .o_valid   (ov_u),
        .o         (o_u),
        .o_hold    (h_u),
        .o_rise    (r_u),
        .match_cnt (cnt_u)
    );

    cmp_qualified #(
        .WIDTH  (8),
        .SIGNED (1),
        .HOLD   (1),
        .CNT_W  (4)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .o_valid   (ov_s),
        .o         (o_s),
        .o_hold    (h_s),
        .o_rise    (r_s),
        .match_cnt (cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit ref_res(logic [7:0] xa, logic [7:0] xb, logic [2:0] m, bit sg);
        int ia;
        int ib;
        ia = int'(xa);
        ib = int'(xb);
        if (sg && ia >= 128) ia = ia - 256;
        if (sg && ib >= 128) ib = ib - 256;
        case (m)
            3'd0:    return ia <= ib;
            3'd1:    return ia < ib;
            3'd2:    return ia == ib;
            3'd3:    return ia != ib;
            3'd4:    return ia >= ib;
            3'd5:    return ia > ib;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(bit r, bit v, logic [7:0] xa, logic [7:0] xb, logic [2:0] m);
        bit res;
        bit prev;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_run[i] = 0; m_hold[i] = 0; m_rise[i] = 0; m_o[i] = 0;
                m_valid[i] = 0; m_cnt[i] = 0; m_mq[i] = 3'd0;
            end else if (!v) begin
                m_valid[i] = 0;
                m_rise[i]  = 0;
            end else begin
                res = ref_res(xa, xb, m, sgn[i]);
                // Length of the current streak of true samples under one mode.
                if (!res) m_run[i] = 0;
                else if (m != m_mq[i]) m_run[i] = 1;
                else m_run[i] = (m_run[i] + 1 > hold_of[i]) ? hold_of[i] : m_run[i] + 1;
                m_mq[i]    = m;
                prev       = m_hold[i];
                m_hold[i]  = (m_run[i] >= hold_of[i]);
                m_rise[i]  = m_hold[i] && !prev;
                m_o[i]     = res;
                m_valid[i] = 1;
                if (res && m_cnt[i] < cmax[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        check("u.o_valid",   32'(ov_u),  32'(m_valid[0]));
        check("u.o",         32'(o_u),   32'(m_o[0]));
        check("u.o_hold",    32'(h_u),   32'(m_hold[0]));
        check("u.o_rise",    32'(r_u),   32'(m_rise[0]));
        check("u.match_cnt", 32'(cnt_u), 32'(m_cnt[0]));
        check("s.o_valid",   32'(ov_s),  32'(m_valid[1]));
        check("s.o",         32'(o_s),   32'(m_o[1]));
        check("s.o_hold",    32'(h_s),   32'(m_hold[1]));
        check("s.o_rise",    32'(r_s),   32'(m_rise[1]));
        check("s.match_cnt", 32'(cnt_s), 32'(m_cnt[1]));
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later, compare to model.
    task automatic cyc(bit r, bit v, logic [7:0] xa, logic [7:0] xb, logic [2:0] m);
        rst      = r;
        in_valid = v;
        a        = xa;
        b        = xb;
        mode     = m;
        @(posedge clk);
        #1;
        model_update(r, v, xa, xb, m);
        check_all();
    endtask

    initial begin
        bit       mode_exp[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0] cur_mode;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0;

        // Reset wins over a valid true sample.
        cyc(1, 1, 8'd3, 8'd5, 3'd0);
        check("reset.o",   32'(o_u),   32'd0);
        check("reset.cnt", 32'(cnt_u), 32'd0);

        // All modes with equal operands.
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 8'd5, 8'd5, 3'(i));
            check($sformatf("mode%0d", i), 32'(o_u), 32'(mode_exp[i]));
        end

        // -1 < 1 only in the signed instance.
        cyc(0, 1, 8'hFF, 8'h01, 3'd1);
        check("signed.lt",   32'(o_s), 32'd1);
        check("unsigned.lt", 32'(o_u), 32'd0);

        // Qualify with gaps between samples.
        cyc(1, 0, 8'd0, 8'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'd1, 8'd2, 3'd0);
            cyc(0, 0, 8'd9, 8'd2, 3'd0);
        end
        check("qual.3", 32'(h_u), 32'd0);
        cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("qual.4.hold", 32'(h_u), 32'd1);
        check("qual.4.rise", 32'(r_u), 32'd1);
        cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("qual.5.rise", 32'(r_u), 32'd0);

        // Break the run after 3, then requalify from scratch.
        cyc(1, 0, 8'd0, 8'd0, 3'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'd1, 8'd2, 3'd0);
        cyc(0, 1, 8'd3, 8'd2, 3'd0);
        check("break.hold", 32'(h_u), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("break.3more", 32'(h_u), 32'd0);
        cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("break.requal", 32'(h_u), 32'd1);

        // Mode change while held drops qualification; 3 more requalify.
        cyc(0, 1, 8'd5, 8'd5, 3'd4);
        check("mchg.hold", 32'(h_u), 32'd0);
        cyc(0, 1, 8'd5, 8'd5, 3'd4);
        cyc(0, 1, 8'd6, 8'd5, 3'd4);
        check("mchg.2", 32'(h_u), 32'd0);
        cyc(0, 1, 8'd7, 8'd5, 3'd4);
        check("mchg.hold2", 32'(h_u), 32'd1);
        check("mchg.rise2", 32'(r_u), 32'd1);

        // Saturation of the 4-bit counter, then reset mid-run.
        cyc(1, 0, 8'd0, 8'd0, 3'd0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("sat.20", 32'(cnt_s), 32'd15);
        cyc(0, 1, 8'd1, 8'd2, 3'd0);
        check("sat.21", 32'(cnt_s), 32'd15);
        check("sat.u21", 32'(cnt_u), 32'd21);
        cyc(1, 1, 8'd1, 8'd2, 3'd0);
        check("sat.rst", 32'(cnt_s), 32'd0);

        // Randomized traffic with sticky modes so qualification is reachable.
        cur_mode = 3'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) cur_mode = 3'($urandom_range(7));
            ra = 8'($urandom_range(255));
            rb = ($urandom_range(3) == 0) ? ra : 8'($urandom_range(255));
            cyc(($urandom_range(59) == 0), ($urandom_range(3) != 0), ra, rb, cur_mode);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
